// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared HH:MM:SS limits, widths and countdown state encoding
package timer_pkg;

    localparam int HOUR_W   = 5;
    localparam int MINUTE_W = 6;
    localparam int SECOND_W = 6;

    localparam logic [SECOND_W-1:0] SECOND_MAX = 6'd59;
    localparam logic [MINUTE_W-1:0] MINUTE_MAX = 6'd59;
    localparam logic [HOUR_W-1:0]   HOUR_MAX   = 5'd23;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef struct packed {
        logic [HOUR_W-1:0]   hour;
        logic [MINUTE_W-1:0] minute;
        logic [SECOND_W-1:0] second;
    } hms_t;

    function automatic hms_t hms_saturate(input logic [HOUR_W-1:0]   h,
                                          input logic [MINUTE_W-1:0] m,
                                          input logic [SECOND_W-1:0] s);
        hms_t r;
        r.hour   = (h > HOUR_MAX)   ? HOUR_MAX   : h;
        r.minute = (m > MINUTE_MAX) ? MINUTE_MAX : m;
        r.second = (s > SECOND_MAX) ? SECOND_MAX : s;
        return r;
    endfunction

endpackage

// File: rtl/hms_decrement.sv
// rtl/hms_decrement.sv - combinational HH:MM:SS minus one second with borrow
module hms_decrement
    import timer_pkg::*;
(
    input  hms_t count,
    output hms_t count_dec,
    output logic is_zero,
    output logic is_one
);

    // 00:00:00 maps to itself so the count can never wrap below zero
    always_comb begin
        count_dec = count;
        if (count.second != '0) begin
            count_dec.second = count.second - 1'b1;
        end else if (count.minute != '0) begin
            count_dec.second = SECOND_MAX;
            count_dec.minute = count.minute - 1'b1;
        end else if (count.hour != '0) begin
            count_dec.second = SECOND_MAX;
            count_dec.minute = MINUTE_MAX;
            count_dec.hour   = count.hour - 1'b1;
        end
    end

    assign is_zero = (count == '0);
    assign is_one  = (count.hour == '0) && (count.minute == '0) &&
                     (count.second == {{(SECOND_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - HH:MM:SS countdown timer with run/pause/expire control
module countdown_timer
    import timer_pkg::*;
(
    input  logic                CLK_IN,
    input  logic                RST_N,
    input  logic                TICK,
    input  logic                LOAD,
    input  logic [HOUR_W-1:0]   LOAD_HOUR,
    input  logic [MINUTE_W-1:0] LOAD_MINUTE,
    input  logic [SECOND_W-1:0] LOAD_SECOND,
    input  logic                START,
    input  logic                PAUSE,
    output logic [HOUR_W-1:0]   HOUR,
    output logic [MINUTE_W-1:0] MINUTE,
    output logic [SECOND_W-1:0] SECOND,
    output logic                BUSY,
    output logic                EXPIRED,
    output logic                DONE_PULSE
);

    logic [1:0] state, state_nxt;
    hms_t       count, count_nxt, count_dec;
    logic       is_zero, is_one;
    logic       done_pulse_q, done_pulse_nxt;

    hms_decrement u_dec (
        .count     (count),
        .count_dec (count_dec),
        .is_zero   (is_zero),
        .is_one    (is_one)
    );

    always_comb begin
        state_nxt      = state;
        count_nxt      = count;
        done_pulse_nxt = 1'b0;
        if (LOAD) begin
            count_nxt = hms_saturate(LOAD_HOUR, LOAD_MINUTE, LOAD_SECOND);
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        state_nxt      = is_zero ? ST_DONE : ST_RUN;
                        done_pulse_nxt = is_zero;
                    end
                end
                ST_RUN: begin
                    // a PAUSE swallows any TICK arriving on the same edge
                    if (PAUSE) begin
                        state_nxt = ST_PAUSED;
                    end else if (TICK) begin
                        count_nxt = count_dec;
                        if (is_one) begin
                            state_nxt      = ST_DONE;
                            done_pulse_nxt = 1'b1;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (START) begin
                        state_nxt = ST_RUN;
                    end
                end
                default: begin
                    state_nxt = ST_DONE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            state        <= ST_IDLE;
            count        <= '0;
            done_pulse_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            done_pulse_q <= done_pulse_nxt;
        end
    end

    assign HOUR       = count.hour;
    assign MINUTE     = count.minute;
    assign SECOND     = count.second;
    assign BUSY       = (state == ST_RUN);
    assign EXPIRED    = (state == ST_DONE);
    assign DONE_PULSE = done_pulse_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - scoreboard bench for countdown_timer against a seconds-total model
module tb_countdown_timer;

    logic       CLK_IN = 1'b0;
    logic       RST_N = 1'b0;
    logic       TICK = 1'b0;
    logic       LOAD = 1'b0;
    logic [4:0] LOAD_HOUR = '0;
    logic [5:0] LOAD_MINUTE = '0;
    logic [5:0] LOAD_SECOND = '0;
    logic       START = 1'b0;
    logic       PAUSE = 1'b0;
    logic [4:0] HOUR;
    logic [5:0] MINUTE;
    logic [5:0] SECOND;
    logic       BUSY;
    logic       EXPIRED;
    logic       DONE_PULSE;

    countdown_timer dut (
        .CLK_IN      (CLK_IN),
        .RST_N       (RST_N),
        .TICK        (TICK),
        .LOAD        (LOAD),
        .LOAD_HOUR   (LOAD_HOUR),
        .LOAD_MINUTE (LOAD_MINUTE),
        .LOAD_SECOND (LOAD_SECOND),
        .START       (START),
        .PAUSE       (PAUSE),
        .HOUR        (HOUR),
        .MINUTE      (MINUTE),
        .SECOND      (SECOND),
        .BUSY        (BUSY),
        .EXPIRED     (EXPIRED),
        .DONE_PULSE  (DONE_PULSE)
    );

    always #5 CLK_IN = ~CLK_IN;

    typedef enum int {M_IDLE, M_RUN, M_PAUSED, M_DONE} mstate_e;

    typedef struct {
        string name;
        int    h;
        int    m;
        int    s;
        bit    busy;
        bit    expired;
        bit    pulse;
    } exp_t;

    exp_t    exp_q[$];
    int      vectors = 0;
    int      miscompares = 0;
    mstate_e m_state = M_IDLE;
    int      m_total = 0;
    bit      m_pulse = 0;

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic exp_t model_expect(input string name);
        exp_t e;
        e.name    = name;
        e.h       = m_total / 3600;
        e.m       = (m_total / 60) % 60;
        e.s       = m_total % 60;
        e.busy    = (m_state == M_RUN);
        e.expired = (m_state == M_DONE);
        e.pulse   = m_pulse;
        return e;
    endfunction

    // Reference: the count is a plain number of remaining seconds
    task automatic model_step(input bit rst, input bit ld, input int lh, input int lm,
                              input int ls, input bit st, input bit ps, input bit tk);
        m_pulse = 0;
        if (rst) begin
            m_state = M_IDLE;
            m_total = 0;
        end else if (ld) begin
            m_total = min_i(lh, 23) * 3600 + min_i(lm, 59) * 60 + min_i(ls, 59);
            m_state = M_IDLE;
        end else begin
            case (m_state)
                M_IDLE: if (st) begin
                    if (m_total == 0) begin
                        m_state = M_DONE;
                        m_pulse = 1;
                    end else begin
                        m_state = M_RUN;
                    end
                end
                M_RUN: if (ps) begin
                    m_state = M_PAUSED;
                end else if (tk) begin
                    m_total = m_total - 1;
                    if (m_total == 0) begin
                        m_state = M_DONE;
                        m_pulse = 1;
                    end
                end
                M_PAUSED: if (st) m_state = M_RUN;
                default: ;
            endcase
        end
    endtask

    task automatic step(input string name, input bit rst_n, input bit ld, input int lh,
                        input int lm, input int ls, input bit st, input bit ps, input bit tk);
        @(negedge CLK_IN);
        RST_N       = rst_n;
        LOAD        = ld;
        LOAD_HOUR   = 5'(lh);
        LOAD_MINUTE = 6'(lm);
        LOAD_SECOND = 6'(ls);
        START       = st;
        PAUSE       = ps;
        TICK        = tk;
        model_step(!rst_n, ld, lh, lm, ls, st, ps, tk);
        exp_q.push_back(model_expect(name));
    endtask

    task automatic check_zero(input string name);
        vectors++;
        if (HOUR !== 5'd0 || MINUTE !== 6'd0 || SECOND !== 6'd0 ||
            BUSY !== 1'b0 || EXPIRED !== 1'b0 || DONE_PULSE !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: got %0d:%0d:%0d busy=%0b exp=%0b pulse=%0b, expected all zero",
                     name, HOUR, MINUTE, SECOND, BUSY, EXPIRED, DONE_PULSE);
        end
    endtask

    // Monitor: every clock edge with a pending expectation is checked
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK_IN);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (HOUR !== 5'(e.h) || MINUTE !== 6'(e.m) || SECOND !== 6'(e.s) ||
                    BUSY !== e.busy || EXPIRED !== e.expired || DONE_PULSE !== e.pulse) begin
                    miscompares++;
                    $display("FAIL %s @%0t: got %0d:%0d:%0d busy=%0b exp=%0b pulse=%0b, expected %0d:%0d:%0d busy=%0b exp=%0b pulse=%0b",
                             e.name, $time, HOUR, MINUTE, SECOND, BUSY, EXPIRED, DONE_PULSE,
                             e.h, e.m, e.s, e.busy, e.expired, e.pulse);
                end
            end
        end
    end

    initial begin
        int budget;
        repeat (2) @(posedge CLK_IN);
        #2;
        check_zero("reset_state");

        // load, start, expire
        step("load3", 1, 1, 0, 0, 3, 0, 0, 0);
        step("start3", 1, 0, 0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) step("tick3", 1, 0, 0, 0, 0, 0, 0, 1);
        step("pulse_drop", 1, 0, 0, 0, 0, 0, 0, 1);
        step("done_ignores", 1, 0, 0, 0, 0, 1, 1, 1);

        // borrow chain through the hour
        step("load1h", 1, 1, 1, 0, 0, 0, 0, 0);
        step("start1h", 1, 0, 0, 0, 0, 1, 0, 0);
        step("borrow", 1, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3599; i++) step("chain", 1, 0, 0, 0, 0, 0, 0, 1);
        step("chain_done", 1, 0, 0, 0, 0, 0, 0, 1);

        // pause discards a same-cycle tick
        step("load10m", 1, 1, 0, 10, 0, 0, 0, 0);
        step("start10m", 1, 0, 0, 0, 0, 1, 0, 0);
        step("pause_tick", 1, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) step("paused_tick", 1, 0, 0, 0, 0, 0, 0, 1);
        step("resume", 1, 0, 0, 0, 0, 1, 1, 0);
        step("resume_tick", 1, 0, 0, 0, 0, 0, 0, 1);

        // saturation and zero start
        step("saturate", 1, 1, 31, 63, 63, 0, 0, 0);
        step("idle_tick", 1, 0, 0, 0, 0, 0, 1, 1);
        step("load0", 1, 1, 0, 0, 0, 0, 0, 0);
        step("start0", 1, 0, 0, 0, 0, 1, 0, 0);
        step("start0_after", 1, 0, 0, 0, 0, 1, 0, 0);

        // load priority over start and tick
        step("load_prio", 1, 1, 0, 0, 5, 1, 0, 1);
        step("tick_idle", 1, 0, 0, 0, 0, 0, 0, 1);

        // asynchronous reset mid-run
        step("start5", 1, 0, 0, 0, 0, 1, 0, 0);
        step("tick5", 1, 0, 0, 0, 0, 0, 0, 1);
        @(posedge CLK_IN);
        #3;
        RST_N = 1'b0;
        #1;
        check_zero("async_reset");
        model_step(1, 0, 0, 0, 0, 0, 0, 0);
        step("in_reset", 0, 0, 0, 0, 0, 1, 0, 1);
        step("first_start", 1, 0, 0, 0, 0, 1, 0, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit ld, st, ps, tk;
            int lh, lm, ls;
            ld = ($urandom_range(0, 39) == 0);
            lh = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : 0;
            lm = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 1));
            ls = int'($urandom_range(0, 63));
            st = ($urandom_range(0, 9) == 0);
            ps = ($urandom_range(0, 14) == 0);
            tk = ($urandom_range(0, 1) == 1);
            step("random", 1, ld, lh, lm, ls, st, ps, tk);
        end

        @(negedge CLK_IN);
        LOAD = 1'b0; START = 1'b0; PAUSE = 1'b0; TICK = 1'b0;
        budget = 0;
        while (exp_q.size() != 0 && budget < 10) begin
            @(posedge CLK_IN);
            budget++;
        end
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
